// File: rtl/regfile_wb_arbiter.sv
// Write-port sequencer/arbiter for the 32x32 RegisterFile: optional post-reset zero-fill
// (enabled by macro RF_INIT_EN), then A/B writeback arbitration with anti-starvation for B.
module regfile_wb_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              init_busy,
    output logic              RegWre,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              last_grant
);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       init_phase_s;
    logic       run_s;
    logic       grant_a_s;
    logic       grant_b_s;

`ifdef RF_INIT_EN
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

    assign init_phase_s = !RST && (state_q == ST_INIT);
    assign run_s        = !RST && (state_q == ST_RUN);
    assign init_busy    = (state_q == ST_INIT);

    // Zero-fill sequencing: walk addresses 1..2**ADDR_W-1, then hand over to arbitration.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (init_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // State and fill-address registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end
`else
    assign init_phase_s = 1'b0;
    assign run_s        = !RST;
    assign init_busy    = 1'b0;
`endif

    // Arbitration: A by default, B when both pend and B has lost STARVE_MAX times in a row.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (run_s) begin
            grant_b_s = b_valid && (!a_valid || (starve_cnt_q == 4'(STARVE_MAX)));
            grant_a_s = a_valid && !grant_b_s;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Port drive toward the RegisterFile; address 0 transfers are accepted but never written.
    always_comb begin
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        RegWre    = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        if (init_phase_s) begin
`ifdef RF_INIT_EN
            RegWre   = 1'b1;
            WriteReg = init_cnt_q;
`else
            RegWre   = 1'b0;
`endif
        end else if (grant_a_s) begin
            a_ready   = 1'b1;
            RegWre    = (a_addr != '0);
            WriteReg  = a_addr;
            WriteData = a_data;
        end else if (grant_b_s) begin
            b_ready   = 1'b1;
            RegWre    = (b_addr != '0);
            WriteReg  = b_addr;
            WriteData = b_data;
        end else begin
            RegWre    = 1'b0;
        end
    end

    // Starvation counter and last-grant tracking.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        last_grant_d = last_grant_q;
        if (run_s) begin
            if (!b_valid || grant_b_s) begin
                starve_cnt_d = 4'd0;
            end else if (grant_a_s && (starve_cnt_q != 4'(STARVE_MAX))) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
            if (grant_a_s) begin
                last_grant_d = 1'b0;
            end else if (grant_b_s) begin
                last_grant_d = 1'b1;
            end else begin
                last_grant_d = last_grant_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
            last_grant_d = last_grant_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt_q <= 4'd0;
            last_grant_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected port activity,
// a negedge monitor pops and compares whenever the DUT accepts or writes.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic        ar;
        logic        br;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        lg;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_addr = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        b_ready;
    logic        init_busy;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        last_grant;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_lg  = 1'b0;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .init_busy(init_busy), .RegWre(RegWre), .WriteReg(WriteReg),
        .WriteData(WriteData), .last_grant(last_grant)
    );

    always #5 CLK = ~CLK;

    // Monitor: every cycle with a handshake or a write must match the next expected entry.
    always @(negedge CLK) begin
        if (a_ready || b_ready || RegWre) begin
            exp_t act;
            exp_t e;
            act = '{a_ready, b_ready, RegWre, WriteReg, WriteData, last_grant};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_xfer: actual ar=%0b br=%0b we=%0b reg=%0d data=%h, required no activity",
                         a_ready, b_ready, RegWre, WriteReg, WriteData);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL xfer: actual ar=%0b br=%0b we=%0b reg=%0d data=%h lg=%0b, required ar=%0b br=%0b we=%0b reg=%0d data=%h lg=%0b",
                             act.ar, act.br, act.we, act.addr, act.data, act.lg,
                             e.ar, e.br, e.we, e.addr, e.data, e.lg);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic expect_xfer(input logic ar, input logic br, input logic we,
                               input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back('{ar, br, we, addr, data, exp_lg});
        if (ar) exp_lg = 1'b0;
        else if (br) exp_lg = 1'b1;
        else exp_lg = exp_lg;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

`ifdef RF_INIT_EN
    task automatic run_init(input int ncyc);
        for (int i = 1; i <= ncyc; i++) begin
            expect_xfer(1'b0, 1'b0, 1'b1, 5'(i), 32'd0);
            check("init_busy_fill", {31'd0, init_busy}, 32'd1);
            step();
        end
    endtask
`endif

    initial begin
        // Reset: first edge, then a second reset cycle with live requests that must be ignored.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        #1;
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check("rst_regwre", {31'd0, RegWre}, 32'd0);
        check("rst_writereg", {27'd0, WriteReg}, 32'd0);
        check("rst_last_grant", {31'd0, last_grant}, 32'd0);
        step();
        RST = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

`ifdef RF_INIT_EN
        run_init(31);
        check("init_done", {31'd0, init_busy}, 32'd0);
`else
        // First post-reset cycle arbitrates immediately.
        drive(1'b1, 5'd5, 32'd7, 1'b0, 5'd0, 32'd0);
        check("no_init_busy", {31'd0, init_busy}, 32'd0);
        expect_xfer(1'b1, 1'b0, 1'b1, 5'd5, 32'd7);
        step();
`endif

        // A only.
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        expect_xfer(1'b1, 1'b0, 1'b1, 5'd3, 32'h33);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("lg_after_a", {31'd0, last_grant}, 32'd0);
        step();

        // Both held: AAAAB AAAAB.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) expect_xfer(1'b0, 1'b1, 1'b1, 5'd2, 32'h22);
            else              expect_xfer(1'b1, 1'b0, 1'b1, 5'd1, 32'h11);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("lg_after_b", {31'd0, last_grant}, 32'd1);
        step();

        // Writes to register 0 are accepted but not performed.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
        expect_xfer(1'b0, 1'b1, 1'b0, 5'd0, 32'hFF);
        step();
        drive(1'b1, 5'd0, 32'h5A, 1'b0, 5'd0, 32'd0);
        expect_xfer(1'b1, 1'b0, 1'b0, 5'd0, 32'h5A);
        step();

        // Same destination: A first, then B's value lands last.
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        expect_xfer(1'b1, 1'b0, 1'b1, 5'd7, 32'hA);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB);
        expect_xfer(1'b0, 1'b1, 1'b1, 5'd7, 32'hB);
        step();

        // B dropping clears its starvation count: 3 A wins, gap, then 4 more before B.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
        for (int k = 0; k < 3; k++) begin
            expect_xfer(1'b1, 1'b0, 1'b1, 5'd4, 32'h44);
            step();
        end
        drive(1'b1, 5'd4, 32'h45, 1'b0, 5'd6, 32'h66);
        expect_xfer(1'b1, 1'b0, 1'b1, 5'd4, 32'h45);
        step();
        drive(1'b1, 5'd4, 32'h46, 1'b1, 5'd6, 32'h66);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) expect_xfer(1'b0, 1'b1, 1'b1, 5'd6, 32'h66);
            else        expect_xfer(1'b1, 1'b0, 1'b1, 5'd4, 32'h46);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();

`ifdef RF_INIT_EN
        // Reset in the middle of zero-fill restarts from register 1.
        RST = 1'b1;
        step();
        RST = 1'b0;
        exp_lg = 1'b0;
        run_init(10);
        RST = 1'b1;
        drive(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0);
        #1;
        check("midinit_rst_ready", {31'd0, a_ready}, 32'd0);
        check("midinit_rst_regwre", {31'd0, RegWre}, 32'd0);
        step();
        RST = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        run_init(31);
        check("reinit_done", {31'd0, init_busy}, 32'd0);
`endif

        step();
        step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: actual still running, required finish");
        $fatal(1, "timeout");
    end

endmodule
